// File: rtl/rca_accum_ctrl.sv
// Serial batch accumulator: one rca_8bit folds each operand into the low byte and its carry into an upper counter.
// Optional shadow exact-sum checker enabled by defining RCA_ACCUM_EXACT_CHK_EN.

module full_adder_acc (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_cell
    full_adder_acc u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[8];
endmodule

module rca_accum_ctrl #(
  parameter  int NUM_OPS = 8,
  parameter  int ACC_W   = 11,
  localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
`ifdef RCA_ACCUM_EXACT_CHK_EN
  output logic [ACC_W-1:0] exact_sum,
  output logic             mismatch,
`endif
  output logic [CNT_W-1:0] out_count
);
  localparam int HI_W = ACC_W - 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t state_p0, state_d;

  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic [7:0] rca_sum;
  logic       rca_cout;
  logic       accept;
  logic       final_beat;
  logic       release_res;

  // Upper bits act as a wrapping carry counter; no saturation by design.
  function automatic logic [HI_W-1:0] fold_carry(input logic [HI_W-1:0] hi, input logic c);
    return hi + HI_W'(c);
  endfunction

  rca_8bit u_rca (
    .a    (acc_p0[7:0]),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  assign accept      = in_valid && in_ready;
  assign final_beat  = in_last || (cnt_p0 == LAST_CNT);
  assign release_res = out_valid && out_ready;

  always_comb begin
    state_d   = state_p0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p0)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && final_beat) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Stage p0: accumulator, operand counter and state advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ACCUM;
      acc_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_d;
      if (accept) begin
        acc_p0 <= {fold_carry(acc_p0[ACC_W-1:8], rca_cout), rca_sum};
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end else if (release_res) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end
    end
  end

  // In DONE the accumulator is frozen, so it doubles as the held result.
  assign result    = acc_p0;
  assign out_count = cnt_p0;

`ifdef RCA_ACCUM_EXACT_CHK_EN
  logic [ACC_W-1:0] exact_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      exact_p0 <= '0;
    end else if (accept) begin
      exact_p0 <= exact_p0 + ACC_W'(in_data);
    end else if (release_res) begin
      exact_p0 <= '0;
    end
  end

  assign exact_sum = exact_p0;
  assign mismatch  = out_valid && (result != exact_p0);
`endif

endmodule

// File: tb/tb_rca_accum_ctrl.sv
// Randomized self-checking bench for rca_accum_ctrl (ACC_W=11 and ACC_W=9 instances share one input stream).
// Expected sums come from an integer model of the accepted operands.

module tb_rca_accum_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = 8'd0;

  logic        in_ready, out_valid;
  logic [10:0] result;
  logic [3:0]  out_count;
  logic        in_ready9, out_valid9;
  logic [8:0]  result9;
  logic [3:0]  out_count9;
`ifdef RCA_ACCUM_EXACT_CHK_EN
  logic [10:0] exact_sum;
  logic        mismatch;
  logic [8:0]  exact_sum9;
  logic        mismatch9;
`endif

  int checks = 0;
  int errors = 0;
  int exp_sum = 0;
  int exp_cnt = 0;

  rca_accum_ctrl #(.NUM_OPS(8), .ACC_W(11)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result),
`ifdef RCA_ACCUM_EXACT_CHK_EN
    .exact_sum(exact_sum), .mismatch(mismatch),
`endif
    .out_count(out_count)
  );

  rca_accum_ctrl #(.NUM_OPS(8), .ACC_W(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid9),
    .out_ready(out_ready), .result(result9),
`ifdef RCA_ACCUM_EXACT_CHK_EN
    .exact_sum(exact_sum9), .mismatch(mismatch9),
`endif
    .out_count(out_count9)
  );

  always #5 clk = ~clk;

  task automatic send_beat(input logic [7:0] d, input logic last);
    int w;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w  = 0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        checks++; errors++; ok = 1'b0;
        $display("FAIL send_beat_timeout in_ready=%0b required 1", in_ready);
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
      exp_sum += int'(d);
      exp_cnt++;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_sum = 0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (result !== 11'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_batch();
    model_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_beat(8'hFF, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %0b want 0", out_valid); end
    send_beat(8'hFF, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency out_valid got %0b want 1", out_valid); end
    checks++; if (result !== 11'(exp_sum % 2048)) begin errors++; $display("FAIL full_result got %0d want %0d", result, exp_sum % 2048); end
    checks++; if (out_count !== 4'(exp_cnt)) begin errors++; $display("FAIL full_count got %0d want %0d", out_count, exp_cnt); end
    checks++; if (result9 !== 9'(exp_sum % 512)) begin errors++; $display("FAIL full_result_w9 got %0d want %0d", result9, exp_sum % 512); end
`ifdef RCA_ACCUM_EXACT_CHK_EN
    checks++; if (exact_sum9 !== 9'(exp_sum % 512) || mismatch9 !== 1'b0) begin errors++; $display("FAIL full_exact_w9 got %0d/%0b want %0d/0", exact_sum9, mismatch9, exp_sum % 512); end
    checks++; if (exact_sum !== 11'(exp_sum % 2048) || mismatch !== 1'b0) begin errors++; $display("FAIL full_exact got %0d/%0b want %0d/0", exact_sum, mismatch, exp_sum % 2048); end
`endif
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL full_release in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_early_last();
    model_clear();
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    send_beat(8'd30, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 11'(exp_sum % 2048)) begin errors++; $display("FAIL last_result got %0d/%0b want %0d/1", result, out_valid, exp_sum % 2048); end
    checks++; if (out_count !== 4'(exp_cnt)) begin errors++; $display("FAIL last_count got %0d want %0d", out_count, exp_cnt); end
    @(posedge clk); #1;
    model_clear();
    for (int i = 0; i < 8; i++) send_beat(8'd1, 1'b0);
    in_valid = 1'b0;
    checks++; if (result !== 11'(exp_sum % 2048) || out_count !== 4'(exp_cnt)) begin errors++; $display("FAIL last_cleared got %0d/%0d want %0d/%0d", result, out_count, exp_sum % 2048, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    model_clear();
    out_ready = 1'b0;
    send_beat(8'd5, 1'b0);
    send_beat(8'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 11'(exp_sum) || out_count !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%0b r=%0b res=%0d cnt=%0d want 1/0/%0d/%0d", i, out_valid, in_ready, result, out_count, exp_sum, exp_cnt);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got v=%0b r=%0b want 0/1", out_valid, in_ready); end
    model_clear();
    send_beat(8'd3, 1'b1);
    in_valid = 1'b0;
    checks++; if (result !== 11'(exp_sum) || out_count !== 4'(exp_cnt)) begin errors++; $display("FAIL hold_nothing_consumed got %0d/%0d want %0d/%0d", result, out_count, exp_sum, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    model_clear();
    for (int i = 0; i < 4; i++) send_beat(8'h80, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_premature_valid got %0b want 0", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (result !== 11'd0 || out_count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_cleared got res=%0d cnt=%0d r=%0b v=%0b want 0/0/1/0", result, out_count, in_ready, out_valid);
    end
    model_clear();
    for (int i = 0; i < 8; i++) send_beat(8'h01, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 11'(exp_sum) || out_count !== 4'(exp_cnt)) begin
      errors++; $display("FAIL abort_next_batch got %0d/%0d want %0d/%0d", result, out_count, exp_sum, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bubbles();
    model_clear();
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      send_beat(8'hFF, 1'b0);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 11'(exp_sum % 2048) || out_count !== 4'(exp_cnt)) begin
      errors++; $display("FAIL bubbles got %0d/%0d want %0d/%0d", result, out_count, exp_sum % 2048, exp_cnt);
    end
    checks++; if (result9 !== 9'(exp_sum % 512)) begin errors++; $display("FAIL bubbles_w9 got %0d want %0d", result9, exp_sum % 512); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n, hold;
    bit last;
    for (int b = 0; b < 20; b++) begin
      model_clear();
      n = $urandom_range(1, 8);
      out_ready = 1'b0;
      for (int i = 1; i <= n; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        last = (i == n) && ((n < 8) || ($urandom_range(0, 1) == 1));
        send_beat(8'($urandom_range(0, 255)), last);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 11'(exp_sum % 2048) || out_count !== 4'(exp_cnt) || result9 !== 9'(exp_sum % 512)) begin
        errors++;
        $display("FAIL random_batch%0d got v=%0b res=%0d cnt=%0d res9=%0d want 1/%0d/%0d/%0d", b, out_valid, result, out_count, result9, exp_sum % 2048, exp_cnt, exp_sum % 512);
      end
`ifdef RCA_ACCUM_EXACT_CHK_EN
      checks++; if (exact_sum !== 11'(exp_sum % 2048) || mismatch !== 1'b0) begin errors++; $display("FAIL random_exact%0d got %0d/%0b want %0d/0", b, exact_sum, mismatch, exp_sum % 2048); end
`endif
      hold = $urandom_range(0, 3);
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_early_last();
    test_backpressure();
    test_reset_abort();
    test_bubbles();
    test_random();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rca_accum_ctrl.md
Name: rca_accum_ctrl

Overview:
Sequencing controller that time-multiplexes one rca_8bit instance to sum a batch of 8-bit operands serially, replacing a full adder tree when area matters.
- Accepts operands on a valid/ready stream.
- Feeds each operand plus the running low byte through rca_8bit, and folds its cout into an upper-bit counter.
- Presents the batch sum on a valid/ready output.
- Sits between the operand source and the result consumer in the adder-tree evaluation path.

Parameters:
NUM_OPS, 8, max operands per batch (>=2)
ACC_W, 11, accumulator/result width (>=9); default holds 8x255 exactly
CNT_W, $clog2(NUM_OPS+1), operand counter width (derived localparam, not overridable)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  controller accepts operand this cycle
in_data  input  8  operand
in_last  input  1  marks final operand of a batch (early termination)
out_valid  output  1  batch result valid
out_ready  input  1  consumer accepts result
result  output  ACC_W  batch sum
out_count  output  CNT_W  number of operands in the batch

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. On a rst cycle, next state is ACCUM, acc=0, cnt=0, out_valid=0, result=0, out_count=0. in_ready is 1 in the first cycle after rst deasserts.
- FSM: two states.
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: a beat is accepted when in_valid&&in_ready. When in_valid=0, acc and cnt hold (bubbles allowed).
- Datapath: one rca_8bit instance, a=acc[7:0], b=in_data. On accept:
  - acc[7:0] <= rca sum.
  - acc[ACC_W-1:8] <= acc[ACC_W-1:8] + cout, wrapping modulo 2^(ACC_W-8). No saturation, no overflow flag.
- Counter: on accept, cnt <= cnt+1.
- Termination: the accepted beat is final if in_last=1 or cnt==NUM_OPS-1. On the final accept the state goes to DONE at the next edge.
  - result=acc including the final operand; out_count=cnt+1.
  - Latency is 1 cycle from final accept to out_valid.
  - in_last on the first beat gives a batch of 1, result=zero-extended in_data.
- DONE: result and out_count are held stable and in_valid is ignored until out_valid&&out_ready. On that edge: acc=0, cnt=0, state=ACCUM.
  - No same-cycle bypass: in_ready rises the cycle after the handshake.
  - Minimum batch period is N+1 cycles.
- Arithmetic fidelity: the result reflects whatever full_adder_acc cells are configured in rca_8bit. With exact cells, result equals the true sum mod 2^ACC_W.
- rst mid-batch or in DONE: the partial or pending result is discarded and the next batch starts clean.

Optional Feature:
RCA_ACCUM_EXACT_CHK_EN
- When defined, a shadow exact accumulator of ACC_W bits, using native "+", is updated on every accept and cleared identically to acc. Two extra outputs are added:
  - exact_sum (ACC_W, valid with out_valid).
  - mismatch (1, = out_valid && (result != exact_sum)).
  - Both reset to 0.
- When undefined, neither the shadow logic nor the ports exist.

Test Plan:
1. 8 back-to-back beats of 8'hFF, out_ready=1 -> out_valid exactly 1 cycle after 8th accept, result=11'd2040, out_count=8, in_ready=1 the cycle after.
2. Beats 10,20,30 with in_last on 30 -> result=60, out_count=3; a following 8-beat batch of 1s gives result=8 (acc cleared).
3. Batch done, out_ready=0 for 5 cycles while in_valid=1 -> out_valid, result and out_count stable, in_ready=0, no beats consumed; out_ready=1 -> handshake, then ACCUM.
4. 4 beats of 8'h80, then rst for 1 cycle, then 8 beats of 8'h01 -> result=8, out_count=8; no output produced for the aborted batch.
5. 8 beats of 8'hFF with random in_valid bubbles -> result=2040, identical to scenario 1 apart from timing.
6. ACC_W=9, 8x8'hFF -> result=9'd504 (2040 mod 512). With RCA_ACCUM_EXACT_CHK_EN and exact cells: exact_sum=504, mismatch=0.
